keypad_entry_ctrl: RTL and testbench

//  Sequences keypad_base key events into a calculator operation: operand A, operator, operand B.

---
 rtl/keypad_entry_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl
//   Turns keypad_base key events into a calculator request:
//   operand A, operator, operand B, then a valid/ready handshake to the ALU.
//   Each physical press produces exactly one event. A key is accepted on the
//   first sensed cycle. The next press is accepted only after valid_in has been
//   low for RELEASE_CYC consecutive cycles.
//
// Ports
//   clk          system clock (keypad_base domain)
//   rst_n        asynchronous active-low reset
//   value        key code from keypad_base
//   valid_in     key held and sensed
//   valid_digit  key is a digit 0-9
//   valid_LR     key is an edit key (value 0 = backspace)
//   operand_a    BCD operand A, digit 0 in [3:0]
//   operand_b    BCD operand B
//   op           operator: 00 add, 01 sub, 10 mul, 11 div
//   calc_valid   request to the ALU, held until calc_ready
//   calc_ready   ALU accepts the request
//   display      operand currently being entered
//   busy         high while a request is outstanding (ISSUE)
//
// state   | meaning
// --------+----------------------------------------------------------
// ENTRY_A | editing operand A
// ENTRY_B | editing operand B, operator latched
// ISSUE   | request presented to the ALU, operands frozen
// DONE    | result handed off; a digit restarts A, an operator chains on A
// -----------------------------------------------------------------------------
module keypad_entry_ctrl #(
  parameter int DIGITS      = 4,
  parameter int RELEASE_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          value,
  input  logic                valid_in,
  input  logic                valid_digit,
  input  logic                valid_LR,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [1:0]          op,
  output logic                calc_valid,
  input  logic                calc_ready,
  output logic [4*DIGITS-1:0] display,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(RELEASE_CYC + 1);
  localparam logic [CW-1:0] REL_LOAD = CW'(RELEASE_CYC);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, ISSUE, DONE} state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Press detector: one accept per press, rearmed by a release down-counter.
  // ---------------------------------------------------------------------------
  logic          armed;
  logic [CW-1:0] rel_cnt;
  logic          accept;

  assign accept = valid_in && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b1;
      rel_cnt <= REL_LOAD;
    end else if (accept) begin
      armed   <= 1'b0;
      rel_cnt <= REL_LOAD;
    end else if (!armed) begin
      if (valid_in) begin
        rel_cnt <= REL_LOAD;
      end else if (rel_cnt == CW'(1)) begin
        armed   <= 1'b1;
        rel_cnt <= REL_LOAD;
      end else begin
        rel_cnt <= rel_cnt - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event register: classify the accepted key; the FSM acts on it one cycle later.
  // ---------------------------------------------------------------------------
  logic       ev_digit;
  logic       ev_bksp;
  logic       ev_cmd;
  logic [3:0] ev_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_digit <= 1'b0;
      ev_bksp  <= 1'b0;
      ev_cmd   <= 1'b0;
      ev_val   <= 4'h0;
    end else begin
      ev_digit <= accept && valid_digit && (value <= 4'd9);
      ev_bksp  <= accept && !valid_digit && valid_LR && (value == 4'h0);
      ev_cmd   <= accept && !valid_digit && !valid_LR;
      ev_val   <= value;
    end
  end

  logic       ev_oper;
  logic       ev_clear;
  logic       ev_equals;
  logic [1:0] op_code;

  assign ev_oper   = ev_cmd && (ev_val >= 4'hA) && (ev_val <= 4'hD);
  assign ev_clear  = ev_cmd && (ev_val == 4'hE);
  assign ev_equals = ev_cmd && (ev_val == 4'hF);
  // A..D map to 00..11: adding 2 to the low bits maps 10,11,00,01 onto 00..11.
  assign op_code   = ev_val[1:0] + 2'd2;

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTRY_A;
      operand_a  <= '0;
      operand_b  <= '0;
      op         <= 2'b00;
      calc_valid <= 1'b0;
    end else if (ev_clear) begin
      state      <= ENTRY_A;
      operand_a  <= '0;
      operand_b  <= '0;
      op         <= 2'b00;
      calc_valid <= 1'b0;
    end else begin
      case (state)
        ENTRY_A: begin
          if (ev_digit) begin
            operand_a <= {operand_a[W-5:0], ev_val};
          end else if (ev_bksp) begin
            operand_a <= {4'h0, operand_a[W-1:4]};
          end else if (ev_oper) begin
            op        <= op_code;
            operand_b <= '0;
            state     <= ENTRY_B;
          end
        end
        ENTRY_B: begin
          if (ev_digit) begin
            operand_b <= {operand_b[W-5:0], ev_val};
          end else if (ev_bksp) begin
            operand_b <= {4'h0, operand_b[W-1:4]};
          end else if (ev_oper) begin
            op <= op_code;
          end else if (ev_equals) begin
            calc_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (calc_valid && calc_ready) begin
            calc_valid <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (ev_digit) begin
            operand_a <= {{(W-4){1'b0}}, ev_val};
            state     <= ENTRY_A;
          end else if (ev_oper) begin
            op        <= op_code;
            operand_b <= '0;
            state     <= ENTRY_B;
          end
        end
        default: state <= ENTRY_A;
      endcase
    end
  end

  assign display = ((state == ENTRY_B) || (state == ISSUE)) ? operand_b : operand_a;
  assign busy    = (state == ISSUE);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry_ctrl
//   Directed keypad sequences against a behavioural model of the entry rules
//   (press = first sensed cycle after a long enough release; operands kept as
//   integers and edited arithmetically). Every cycle the DUT outputs are
//   compared with the model. Literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int RC     = 16;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   value = 4'h0;
  logic         valid_in = 1'b0;
  logic         valid_digit = 1'b0;
  logic         valid_LR = 1'b0;
  logic         calc_ready = 1'b0;
  logic [W-1:0] operand_a, operand_b, display;
  logic [1:0]   op;
  logic         calc_valid, busy;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .RELEASE_CYC(RC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .valid_in(valid_in),
    .valid_digit(valid_digit), .valid_LR(valid_LR),
    .operand_a(operand_a), .operand_b(operand_b), .op(op),
    .calc_valid(calc_valid), .calc_ready(calc_ready),
    .display(display), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int PH_A = 0, PH_B = 1, PH_ISSUE = 2, PH_DONE = 3;
  localparam int K_NONE = 0, K_DIGIT = 1, K_BKSP = 2, K_CMD = 3;
  localparam int MOD = 1 << W;

  int m_a, m_b, m_op, m_cv, m_ph;
  int m_low;        // consecutive cycles valid_in has been low since last press
  int m_kind, m_kval;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_cv = 0; m_ph = PH_A;
      m_low = RC; m_kind = K_NONE; m_kval = 0;
    end else begin
      // act on the key accepted last cycle
      if (m_kind == K_CMD && m_kval == 14) begin
        m_a = 0; m_b = 0; m_op = 0; m_cv = 0; m_ph = PH_A;
      end else begin
        case (m_ph)
          PH_A: begin
            if (m_kind == K_DIGIT) m_a = (m_a * 16 + m_kval) % MOD;
            else if (m_kind == K_BKSP) m_a = m_a / 16;
            else if (m_kind == K_CMD && m_kval >= 10 && m_kval <= 13) begin
              m_op = m_kval - 10; m_b = 0; m_ph = PH_B;
            end
          end
          PH_B: begin
            if (m_kind == K_DIGIT) m_b = (m_b * 16 + m_kval) % MOD;
            else if (m_kind == K_BKSP) m_b = m_b / 16;
            else if (m_kind == K_CMD && m_kval >= 10 && m_kval <= 13) m_op = m_kval - 10;
            else if (m_kind == K_CMD && m_kval == 15) begin
              m_cv = 1; m_ph = PH_ISSUE;
            end
          end
          PH_ISSUE: begin
            if (m_cv == 1 && calc_ready) begin
              m_cv = 0; m_ph = PH_DONE;
            end
          end
          default: begin
            if (m_kind == K_DIGIT) begin
              m_a = m_kval; m_ph = PH_A;
            end else if (m_kind == K_CMD && m_kval >= 10 && m_kval <= 13) begin
              m_op = m_kval - 10; m_b = 0; m_ph = PH_B;
            end
          end
        endcase
      end
      // classify this cycle's press
      m_kind = K_NONE;
      m_kval = int'(value);
      if (valid_in && m_low >= RC) begin
        if (valid_digit) m_kind = (value <= 9) ? K_DIGIT : K_NONE;
        else if (valid_LR) m_kind = (value == 0) ? K_BKSP : K_NONE;
        else m_kind = K_CMD;
      end
      if (valid_in) m_low = 0;
      else if (m_low < RC) m_low++;
    end
  end

  int cv_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("operand_a", operand_a, m_a);
      chk("operand_b", operand_b, m_b);
      chk("op", op, m_op);
      chk("calc_valid", calc_valid, m_cv);
      chk("busy", busy, (m_ph == PH_ISSUE) ? 1 : 0);
      chk("display", display, (m_ph == PH_B || m_ph == PH_ISSUE) ? m_b : m_a);
      if (calc_valid) cv_cycles++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic key_up();
    valid_in = 1'b0; valid_digit = 1'b0; valid_LR = 1'b0; value = 4'h0;
  endtask

  task automatic press(input logic [3:0] v, input logic d, input logic lr);
    @(negedge clk);
    value = v; valid_digit = d; valid_LR = lr; valid_in = 1'b1;
    repeat (3) @(negedge clk);
    key_up();
    repeat (RC + 3) @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d);
    press(d, 1'b1, 1'b0);
  endtask

  task automatic cmd(input logic [3:0] c);
    press(c, 1'b0, 1'b0);
  endtask

  task automatic bksp();
    press(4'h0, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, operand_a, 0);
    chk({tag, "_b"}, operand_b, 0);
    chk({tag, "_op"}, op, 0);
    chk({tag, "_cv"}, calc_valid, 0);
    chk({tag, "_disp"}, display, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 12 + 34 = with the ALU always ready
    calc_ready = 1'b1;
    cv_cycles  = 0;
    dig(1); dig(2); cmd(4'hA); dig(3); dig(4); cmd(4'hF);
    chk("t1_cv_cycles", cv_cycles, 1);
    chk("t1_a", operand_a, 16'h0012);
    chk("t1_b", operand_b, 16'h0034);
    chk("t1_op", op, 0);
    chk("t1_disp", display, 16'h0012);

    // 3: five digits wrap, then backspace
    cmd(4'hE);
    dig(1); dig(2); dig(3); dig(4); dig(5);
    chk("t3_a_wrap", operand_a, 16'h2345);
    bksp();
    chk("t3_a_bksp", operand_a, 16'h0234);
    press(4'h3, 1'b0, 1'b1);          // non-backspace edit key
    chk("t3_lr_ignored", operand_a, 16'h0234);

    // 2: long hold with sense dropouts, short release, then full release
    cmd(4'hE);
    @(negedge clk);
    value = 4'h5; valid_digit = 1'b1;
    for (int i = 0; i < 500; i++) begin
      valid_in = ((i % 50) < 47);
      @(negedge clk);
    end
    valid_in = 1'b0;
    repeat (RC - 6) @(negedge clk);
    valid_in = 1'b1;
    repeat (20) @(negedge clk);
    key_up();
    repeat (RC + 4) @(negedge clk);
    chk("t2_single", operand_a, 16'h0005);
    dig(5);
    chk("t2_second", operand_a, 16'h0055);

    // 4: 1 x 2 = with the ALU stalled
    cmd(4'hE);
    calc_ready = 1'b0;
    dig(1); cmd(4'hC); dig(2); cmd(4'hF);
    dig(7); cmd(4'hA);
    chk("t4_cv_held", calc_valid, 1);
    chk("t4_busy", busy, 1);
    chk("t4_a", operand_a, 16'h0001);
    chk("t4_b", operand_b, 16'h0002);
    chk("t4_op", op, 2);
    @(negedge clk);
    calc_ready = 1'b1;
    @(negedge clk);
    chk("t4_cv_dropped", calc_valid, 0);
    chk("t4_done_disp", display, 16'h0001);
    chk("t4_done_busy", busy, 0);

    // 5: clear during ISSUE, then chain a subtract from DONE
    calc_ready = 1'b0;
    cmd(4'hE);
    dig(1); cmd(4'hA); dig(2); cmd(4'hF);
    chk("t5_in_issue", busy, 1);
    cmd(4'hE);
    check_all_zero("t5_clear");
    calc_ready = 1'b1;
    dig(3); cmd(4'hA); dig(4); cmd(4'hF);
    cmd(4'hB);
    chk("t5_chain_op", op, 1);
    chk("t5_chain_a", operand_a, 16'h0003);
    chk("t5_chain_b", operand_b, 16'h0000);
    dig(9);
    chk("t5_chain_disp", display, 16'h0009);

    // 6a: reset mid-entry with a key held across reset release
    cmd(4'hE);
    dig(1); dig(2);
    @(negedge clk);
    value = 4'h7; valid_digit = 1'b1; valid_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_entry");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    key_up();
    repeat (RC + 4) @(negedge clk);
    chk("t6_held_once", operand_a, 16'h0007);

    // 6b: reset mid-ISSUE
    calc_ready = 1'b0;
    cmd(4'hA); dig(8); cmd(4'hF);
    chk("t6_in_issue", calc_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_issue");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
